// File: rtl/pads_config_ctrl_if.sv
// Pad configuration bus: parallel/serial shadow load, apply handshake and pad control outputs.
interface pads_config_ctrl_if #(
    parameter int unsigned NUM_PADS = 44
);
    logic [NUM_PADS-1:0] wr_en;
    logic [NUM_PADS-1:0] wr_oe;
    logic [NUM_PADS-1:0] wr_re;
    logic                cfg_shift;
    logic                cfg_sin;
    logic                cfg_sout;
    logic                apply;
    logic                apply_done;
    logic                hold_busy;
    logic [NUM_PADS-1:0] oe;
    logic [NUM_PADS-1:0] re;

    modport master (
        output wr_en, wr_oe, wr_re, cfg_shift, cfg_sin, apply,
        input  cfg_sout, apply_done, hold_busy, oe, re
    );

    modport slave (
        input  wr_en, wr_oe, wr_re, cfg_shift, cfg_sin, apply,
        output cfg_sout, apply_done, hold_busy, oe, re
    );
endinterface

// File: rtl/pads_config_ctrl.sv
// Pad OE/RE controller: shadow register (parallel or serial load) copied to active on apply,
// with resistor enables held off for RE_HOLD cycles after reset release.
module pads_config_ctrl #(
    parameter int unsigned NUM_PADS = 44,
    parameter logic [63:0] OE_RST   = 64'hC70003FFFBD,
    parameter logic [63:0] RE_RST   = '1,
    parameter int unsigned RE_HOLD  = 16
) (
    input  logic                clk,
    input  logic                rst,
    pads_config_ctrl_if.slave   bus
);

    localparam int unsigned SH_W  = 2 * NUM_PADS;
    localparam int unsigned CNT_W = 16;
    localparam logic [NUM_PADS-1:0] OE_INIT = OE_RST[NUM_PADS-1:0];
    localparam logic [NUM_PADS-1:0] RE_INIT = RE_RST[NUM_PADS-1:0];
    localparam logic [CNT_W-1:0] CNT_LAST = (RE_HOLD == 0) ? '0 : CNT_W'(RE_HOLD - 1);

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_e;

    logic [SH_W-1:0]     sh_q, sh_d;
    logic [NUM_PADS-1:0] act_oe_q, act_oe_d;
    logic [NUM_PADS-1:0] act_re_q, act_re_d;
    logic                apply_done_q, apply_done_d;
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_PADS-1:0] sh_oe, sh_re;
    assign sh_oe = sh_q[NUM_PADS-1:0];
    assign sh_re = sh_q[SH_W-1:NUM_PADS];

    // Next-state: shadow load, apply copy and RE hold sequencing
    always_comb begin
        sh_d         = sh_q;
        act_oe_d     = act_oe_q;
        act_re_d     = act_re_q;
        apply_done_d = bus.apply;
        state_d      = state_q;
        cnt_d        = cnt_q;

        // Shift wins over parallel write in the same cycle
        if (bus.cfg_shift) begin
            sh_d = {bus.cfg_sin, sh_q[SH_W-1:1]};
        end else begin
            sh_d = {(sh_re & ~bus.wr_en) | (bus.wr_re & bus.wr_en),
                    (sh_oe & ~bus.wr_en) | (bus.wr_oe & bus.wr_en)};
        end

        // Apply takes the shadow as it was before this edge
        if (bus.apply) begin
            act_oe_d = sh_oe;
            act_re_d = sh_re;
        end

        unique case (state_q)
            HOLD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if ((RE_HOLD == 0) || (cnt_q == CNT_LAST)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q         <= {RE_INIT, OE_INIT};
            act_oe_q     <= OE_INIT;
            act_re_q     <= RE_INIT;
            apply_done_q <= 1'b0;
            state_q      <= HOLD;
            cnt_q        <= '0;
        end else begin
            sh_q         <= sh_d;
            act_oe_q     <= act_oe_d;
            act_re_q     <= act_re_d;
            apply_done_q <= apply_done_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.oe         = act_oe_q;
    assign bus.re         = act_re_q & {NUM_PADS{(state_q == RUN) && !rst}};
    assign bus.hold_busy  = (state_q == HOLD);
    assign bus.cfg_sout   = sh_q[0];
    assign bus.apply_done = apply_done_q;

endmodule
